// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage sitting directly in front of the instruction memory. It owns the
// program counter, presents the word address to imem combinationally, captures
// the returned instruction word and buffers up to two {pc, instr} entries. The
// entries are handed to decode over a valid/ready handshake. A redirect from
// execute reloads the PC and flushes everything buffered.
//
// Optional feature macro: FETCH_PERF_EN
//   When defined, the perf_fetched and perf_flushed counter ports are added.
//
// Ports
//   clk            in   1       rising-edge clock
//   reset_n        in   1       asynchronous active-low reset
//   fetch_en       in   1       1 = fetch allowed, 0 = hold PC and stop pushing
//   imem_addr      out  ADDR_W  word address to imem (pc[ADDR_W+1:2])
//   imem_data      in   32      instruction word from imem (combinational)
//   redirect_valid in   1       load redirect_pc and flush the queue
//   redirect_pc    in   PC_W    redirect target, low two bits ignored
//   out_valid      out  1       queue head valid
//   out_ready      in   1       decode accepts the head this cycle
//   out_instr      out  32      head instruction word
//   out_pc         out  PC_W    head PC
//   out_pc_plus4   out  PC_W    head PC + 4
//   perf_fetched   out  32      (FETCH_PERF_EN) entries popped by decode
//   perf_flushed   out  32      (FETCH_PERF_EN) entries discarded by redirects
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              PC_W     = 32,
    parameter int              ADDR_W   = 6,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);

    localparam logic [PC_W-1:0] PC_STEP     = PC_W'(32'd4);
    localparam logic [PC_W-1:0] PC_RESET_AL = {RESET_PC[PC_W-1:2], 2'b00};

    // Architectural state: PC plus a two-deep shift queue (entry 0 is the head).
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] e0_pc_r;
    logic [PC_W-1:0] e1_pc_r;
    logic [31:0]     e0_instr_r;
    logic [31:0]     e1_instr_r;
    logic [1:0]      count_r;

    logic [PC_W-1:0] pc_nxt_s;
    logic [PC_W-1:0] e0_pc_nxt_s;
    logic [PC_W-1:0] e1_pc_nxt_s;
    logic [31:0]     e0_instr_nxt_s;
    logic [31:0]     e1_instr_nxt_s;
    logic [1:0]      count_nxt_s;

    logic            full_s;
    logic            push_s;
    logic            pop_s;
    logic            unused_s;

    // The low redirect bits are deliberately dropped; keep them visibly consumed.
    assign unused_s  = ^redirect_pc[1:0];

    // Fullness is judged on the pre-pop count, so a pop never frees room for a
    // push in the same cycle.
    assign full_s    = (count_r == 2'd2);
    assign push_s    = fetch_en & ~full_s & ~redirect_valid;
    assign pop_s     = out_valid & out_ready;

    assign imem_addr    = pc_r[ADDR_W+1:2];
    assign out_valid    = (count_r != 2'd0);
    assign out_pc       = e0_pc_r;
    assign out_instr    = e0_instr_r;
    assign out_pc_plus4 = e0_pc_r + PC_STEP;

    // Next-state for PC and queue; a redirect overrides push and pop.
    always_comb begin
        pc_nxt_s       = pc_r;
        e0_pc_nxt_s    = e0_pc_r;
        e1_pc_nxt_s    = e1_pc_r;
        e0_instr_nxt_s = e0_instr_r;
        e1_instr_nxt_s = e1_instr_r;
        count_nxt_s    = count_r;

        if (redirect_valid) begin
            pc_nxt_s    = {redirect_pc[PC_W-1:2], 2'b00};
            count_nxt_s = 2'd0;
        end else begin
            if (push_s) begin
                pc_nxt_s = pc_r + PC_STEP;
            end else begin
                pc_nxt_s = pc_r;
            end

            case ({push_s, pop_s})
                2'b01: begin
                    e0_pc_nxt_s    = e1_pc_r;
                    e0_instr_nxt_s = e1_instr_r;
                    count_nxt_s    = count_r - 2'd1;
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        e0_pc_nxt_s    = pc_r;
                        e0_instr_nxt_s = imem_data;
                    end else begin
                        e1_pc_nxt_s    = pc_r;
                        e1_instr_nxt_s = imem_data;
                    end
                    count_nxt_s = count_r + 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: the new word becomes the head.
                    e0_pc_nxt_s    = pc_r;
                    e0_instr_nxt_s = imem_data;
                    count_nxt_s    = count_r;
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // PC and queue registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r       <= PC_RESET_AL;
            e0_pc_r    <= '0;
            e1_pc_r    <= '0;
            e0_instr_r <= 32'd0;
            e1_instr_r <= 32'd0;
            count_r    <= 2'd0;
        end else begin
            pc_r       <= pc_nxt_s;
            e0_pc_r    <= e0_pc_nxt_s;
            e1_pc_r    <= e1_pc_nxt_s;
            e0_instr_r <= e0_instr_nxt_s;
            e1_instr_r <= e1_instr_nxt_s;
            count_r    <= count_nxt_s;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_flushed_r;
    logic [1:0]  flush_cnt_s;

    // A pop coincident with a redirect still reaches decode, so only the
    // remaining entries count as flushed.
    assign flush_cnt_s  = count_r - {1'b0, pop_s};
    assign perf_fetched = perf_fetched_r;
    assign perf_flushed = perf_flushed_r;

    // Free-running performance counters, wrapping modulo 2**32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_r <= 32'd0;
            perf_flushed_r <= 32'd0;
        end else begin
            if (pop_s) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end else begin
                perf_fetched_r <= perf_fetched_r;
            end
            if (redirect_valid) begin
                perf_flushed_r <= perf_flushed_r + {30'd0, flush_cnt_s};
            end else begin
                perf_flushed_r <= perf_flushed_r;
            end
        end
    end
`endif

endmodule
